truth_table_sweeper: RTL and testbench

//   Upstream stimulus source and downstream checker for a 3-input combinational

---
 rtl/truth_table_sweeper_pkg.sv | 17 +
 rtl/truth_table_sweeper_settle_timer.sv | 40 ++++
 rtl/truth_table_sweeper.sv | 129 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and
// reference truth tables for the boolean exercise expressions.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Truth table of (x'.y)'.z, bit i = f(vec == i)
  localparam logic [7:0] FXY4_TT  = 8'hA2;
  // Truth table of x'
  localparam logic [7:0] NOT_X_TT = 8'h0F;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter that measures how long a stimulus vector has been
// held; zero tells the sweeper that the stage has had time to settle.
module tt_settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load takes priority; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked stimulus source and checker for an N_IN-input combinational stage:
// sweeps every input vector, samples the stage output after a settle time,
// builds the captured truth table and counts rows that differ from EXPECT.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                    N_IN   = 3,
  parameter int                    SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECT = FXY4_TT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_o,
  input  logic                   s_i,
  output logic                   busy,
  output logic                   done,
  output logic [(2**N_IN)-1:0]   table_o,
  output logic [N_IN:0]          err_cnt,
  output logic                   pass
);

  localparam int                 ROWS        = 2**N_IN;
  localparam int                 TW          = $clog2(SETTLE) + 1;
  localparam logic [TW-1:0]      SETTLE_LOAD = TW'(SETTLE - 1);
  localparam logic [N_IN-1:0]    LAST_VEC    = N_IN'(ROWS - 1);
  localparam logic [N_IN-1:0]    VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]      ERR_ONE     = (N_IN + 1)'(1);

  state_e                state_q, state_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic [ROWS-1:0]       table_q, table_d;
  logic [N_IN:0]         err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  timer_load;
  logic                  timer_en;
  logic                  timer_zero;

  tt_settle_timer #(
    .WIDTH (TW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  // Next-state, vector stepping, capture and error counting
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    table_d    = table_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          table_d    = '0;
          err_d      = '0;
          timer_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        table_d[vec_q] = s_i;
        if (s_i != EXPECT[vec_q]) begin
          err_d = err_q + ERR_ONE;
        end
        if (vec_q == LAST_VEC) begin
          state_d = ST_DONE;
        end else begin
          vec_d      = vec_q + VEC_ONE;
          timer_load = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and registered outputs; reset aborts any sweep in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_o = table_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (SETTLE=1 with
// the fxy4 table, SETTLE=3 with the x' table) each drive a behavioural stage
// model; expectations come from evaluating the stage for all eight vectors.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Per-instance stimulus, index 0 = SETTLE 1, index 1 = SETTLE 3
  logic       start [2];
  int         mode [2];
  logic [7:0] rand_tt [2];

  logic       s_a, s_b;
  logic [2:0] vec_a, vec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] table_a, table_b;
  logic [3:0] err_a, err_b;

  // Gathered views of both instances for the tasks
  logic [2:0] vec_o [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [7:0] table_o [2];
  logic [3:0] err_cnt [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(
    .N_IN   (3),
    .SETTLE (1),
    .EXPECT (FXY4_TT)
  ) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start[0]),
    .vec_o   (vec_a),
    .s_i     (s_a),
    .busy    (busy_a),
    .done    (done_a),
    .table_o (table_a),
    .err_cnt (err_a),
    .pass    (pass_a)
  );

  truth_table_sweeper #(
    .N_IN   (3),
    .SETTLE (3),
    .EXPECT (NOT_X_TT)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start[1]),
    .vec_o   (vec_b),
    .s_i     (s_b),
    .busy    (busy_b),
    .done    (done_b),
    .table_o (table_b),
    .err_cnt (err_b),
    .pass    (pass_b)
  );

  function automatic int settleOf(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] expectOf(int d);
    return (d == 0) ? 8'hA2 : 8'h0F;
  endfunction

  // Behavioural stage under test: 0 = (x'.y)'.z, 1 = its complement,
  // 2 = stuck at 0, otherwise an arbitrary lookup table
  function automatic logic stageFn(int m, logic [2:0] v, logic [7:0] tt);
    logic x, y, z;
    x = v[2];
    y = v[1];
    z = v[0];
    case (m)
      0:       return ~(~x & y) & z;
      1:       return ~(~(~x & y) & z);
      2:       return 1'b0;
      default: return tt[v];
    endcase
  endfunction

  // Stage outputs respond combinationally to each instance's vector
  always_comb begin
    s_a = stageFn(mode[0], vec_a, rand_tt[0]);
    s_b = stageFn(mode[1], vec_b, rand_tt[1]);
  end

  // Collect both instances into indexable arrays
  always_comb begin
    vec_o[0]   = vec_a;   vec_o[1]   = vec_b;
    busy[0]    = busy_a;  busy[1]    = busy_b;
    done[0]    = done_a;  done[1]    = done_b;
    pass[0]    = pass_a;  pass[1]    = pass_b;
    table_o[0] = table_a; table_o[1] = table_b;
    err_cnt[0] = err_a;   err_cnt[1] = err_b;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdle(input int d, input string tag);
    checkOutput({tag, "_vec"},   32'(vec_o[d]),   32'd0);
    checkOutput({tag, "_busy"},  32'(busy[d]),    32'd0);
    checkOutput({tag, "_done"},  32'(done[d]),    32'd0);
    checkOutput({tag, "_table"}, 32'(table_o[d]), 32'd0);
    checkOutput({tag, "_err"},   32'(err_cnt[d]), 32'd0);
    checkOutput({tag, "_pass"},  32'(pass[d]),    32'd0);
  endtask

  // Run one sweep on instance d; optionally re-pulse start at cycles g1/g2
  // (k counts rising edges after the edge that samples start) or drop
  // reset at cycle abort_k
  task automatic applyStimulus(input int d, input int m, input logic [7:0] tt,
                               input int g1, input int g2, input int abort_k);
    int         s;
    int         lat;
    int         exp_vec;
    int         exp_err;
    logic [7:0] exp_tt;
    s   = settleOf(d);
    lat = 8 * (s + 1);
    mode[d]    = m;
    rand_tt[d] = tt;
    for (int i = 0; i < 8; i++) begin
      exp_tt[i] = stageFn(m, 3'(i), tt);
    end
    exp_err = $countones(exp_tt ^ expectOf(d));

    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    checkOutput("start_table_clr", 32'(table_o[d]), 32'd0);
    checkOutput("start_err_clr",   32'(err_cnt[d]), 32'd0);
    checkOutput("start_done_low",  32'(done[d]),    32'd0);
    checkOutput("start_pass_low",  32'(pass[d]),    32'd0);
    checkOutput("start_busy",      32'(busy[d]),    32'd1);
    checkOutput("start_vec",       32'(vec_o[d]),   32'd0);

    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      start[d] = 1'b0;
      exp_vec = k / (s + 1);
      if (exp_vec > 7) exp_vec = 7;
      checkOutput("sweep_vec",  32'(vec_o[d]), 32'(exp_vec));
      checkOutput("sweep_busy", 32'(busy[d]),  (k < lat) ? 32'd1 : 32'd0);
      checkOutput("sweep_done", 32'(done[d]),  (k >= lat) ? 32'd1 : 32'd0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        checkIdle(d, "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkIdle(d, "post_rst_idle");
        return;
      end
      if (k == g1 || k == g2) start[d] = 1'b1;
    end

    checkOutput("final_table", 32'(table_o[d]), 32'(exp_tt));
    checkOutput("final_err",   32'(err_cnt[d]), 32'(exp_err));
    checkOutput("final_pass",  32'(pass[d]),    (exp_err == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int d;
    int g;
    start[0] = 1'b0;   start[1] = 1'b0;
    mode[0] = 0;       mode[1] = 0;
    rand_tt[0] = 8'h0; rand_tt[1] = 8'h0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle(0, "reset_a");
    checkIdle(1, "reset_b");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] matching stage, SETTLE=1");
    applyStimulus(0, 0, 8'h00, -1, -1, -1);
    $display("[TB] inverted stage restarted from DONE");
    applyStimulus(0, 1, 8'h00, -1, -1, -1);
    $display("[TB] stage stuck at 0");
    applyStimulus(0, 2, 8'h00, -1, -1, -1);
    $display("[TB] SETTLE=3 instance against x' table");
    applyStimulus(1, 0, 8'h00, -1, -1, -1);
    $display("[TB] start while busy and in the cycle done rises");
    applyStimulus(0, 0, 8'h00, 7, 15, -1);
    applyStimulus(0, 1, 8'h00, -1, -1, -1);
    $display("[TB] reset mid-sweep at vector 5");
    applyStimulus(0, 0, 8'h00, -1, -1, 11);
    applyStimulus(0, 0, 8'h00, -1, -1, -1);

    $display("[TB] randomized tables");
    for (int r = 0; r < 8; r++) begin
      d = int'($urandom_range(0, 1));
      g = int'($urandom_range(1, 8 * (settleOf(d) + 1) - 1));
      applyStimulus(d, 3, 8'($urandom), g, -1, -1);
    end
    applyStimulus(1, 3, 8'h0F, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
